lockin_reg_master: RTL
======================

LOCKIN_REG_MASTER -- requirements
Module: lockin_reg_master

Interface
REQ-001 Parameter ADDR_W, default 2, Avalon-MM word address width.
REQ-002 Parameter READ_LATENCY, default 0, fixed slave read latency in cycles (0..3).
REQ-003 Parameter TIMEOUT, default 255, maximum waitrequest cycles before abort (1..255).
REQ-004 The block SHALL use reset reset_n, asynchronous, active-low, and clock clk.
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target word address.
REQ-011 cmd_wdata  in  32  write data.
REQ-012 rsp_valid  out  1  one-cycle completion strobe.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-014 rsp_timeout  out  1  completion was an abort; qualified by rsp_valid.
REQ-015 chipselect  out  1  Avalon-MM select.
REQ-016 write_n  out  1  active-low write.
REQ-017 read_n  out  1  active-low read.
REQ-018 address  out  ADDR_W  Avalon-MM address.
REQ-019 writedata  out  32  Avalon-MM write data.
REQ-020 readdata  in  32  Avalon-MM read data.
REQ-021 waitrequest  in  1  slave stall; tie 0 for zero-wait PIO slaves.

Function
REQ-022 FSM SHALL have states IDLE, BUS, RDWAIT, RESP.
REQ-023 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE is ignored, not queued.
REQ-024 On cmd_valid&cmd_ready the block SHALL register cmd_write/addr/wdata and enter BUS next cycle.
REQ-025 In BUS: chipselect=1, write_n=~cmd_write, read_n=cmd_write, address/writedata from the registered command, all registered outputs.
REQ-026 In BUS with waitrequest=1: hold all bus outputs, increment wait counter; when counter equals TIMEOUT, go RESP with rsp_timeout=1, rsp_rdata=0.
REQ-027 In BUS with waitrequest=0: write -> RESP; read with READ_LATENCY=0 -> capture readdata this cycle, go RESP; read with READ_LATENCY>0 -> RDWAIT.
REQ-028 RDWAIT: bus outputs idle, count READ_LATENCY cycles, capture readdata on the last, go RESP.
REQ-029 RESP: rsp_valid=1 exactly one cycle, then IDLE; rsp_rdata/rsp_timeout hold until the next RESP.
REQ-030 Idle bus values: chipselect=0, write_n=1, read_n=1, address=0, writedata=0.
REQ-031 Latency, write, waitrequest=0: accept cycle N, bus N+1, rsp_valid N+2, cmd_ready N+3.
REQ-032 write_n and read_n SHALL never both be 0.
REQ-033 Wait counter SHALL clear on entry to BUS; it is 8 bits and never wraps.

Reset
REQ-034 On reset_n=0, all outputs SHALL go to idle bus values, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, state IDLE, counters 0, immediately, including mid-transaction.
REQ-035 cmd_ready SHALL assert the first clk edge after reset_n deasserts.

Structure
REQ-036 Package lockin_reg_pkg SHALL hold the state enum and default constants (ADDR_W, READ_LATENCY, TIMEOUT).
REQ-037 One sub-module lockin_wait_counter (clear, enable, terminal-count compare) SHALL serve both timeout and read-latency counting.

Verification
REQ-038 Write addr 0, data 0x000000A5 to zero-wait PIO model -> out_port=0xA5, rsp_valid at N+2, rsp_rdata=0, rsp_timeout=0.
REQ-039 Read addr 0 after REQ-038 -> rsp_rdata=0x000000A5; READ_LATENCY=2 -> rsp_valid at N+4.
REQ-040 waitrequest=1 for 3 cycles on write -> chipselect high 4 cycles, writedata stable, single write committed.
REQ-041 TIMEOUT=8, waitrequest stuck 1 -> rsp_valid with rsp_timeout=1 after 8 wait cycles; bus idle next cycle.
REQ-042 reset_n pulsed low during BUS -> chipselect=0 asynchronously, no rsp_valid, next command completes normally.
REQ-043 cmd_valid held high for two back-to-back writes -> second accepted only at N+3, two distinct bus cycles.

Source files
------------

// File: rtl/lockin_reg_pkg.sv
// rtl/lockin_reg_pkg.sv - shared state type and default constants for the lock-in register master
package lockin_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS    = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int DEF_ADDR_W       = 2;
    localparam int DEF_READ_LATENCY = 0;
    localparam int DEF_TIMEOUT      = 255;
    localparam int CNT_W            = 8;

endpackage

// File: rtl/lockin_wait_counter.sv
// rtl/lockin_wait_counter.sv - saturating 8-bit cycle counter with terminal-count compare
module lockin_wait_counter
    import lockin_reg_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable; the count saturates instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Hit fires on the enabled cycle that completes the terminal count.
    assign hit = enable && !clear && (count_q == terminal);

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lockin_reg_master.sv
// rtl/lockin_reg_master.sv - single-outstanding command to Avalon-MM master with timeout
module lockin_reg_master
    import lockin_reg_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_timeout,
    output logic              chipselect,
    output logic              write_n,
    output logic              read_n,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    input  logic              waitrequest
);

    // Terminal counts are one less than the cycle counts since the hit cycle is the last one.
    localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RL_TERM = (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;

    state_e              state_q,       state_d;
    logic                cmd_ready_q,   cmd_ready_d;
    logic                cmd_write_q,   cmd_write_d;
    logic                chipselect_q,  chipselect_d;
    logic                write_n_q,     write_n_d;
    logic                read_n_q,      read_n_d;
    logic [ADDR_W-1:0]   address_q,     address_d;
    logic [31:0]         writedata_q,   writedata_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [31:0]         rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic                cnt_clear;
    logic                cnt_enable;
    logic [CNT_W-1:0]    cnt_terminal;
    logic                cnt_hit;
    logic                go_resp;
    logic                bus_release;

    // One counter measures either waitrequest stalls (BUS) or read latency (RDWAIT).
    lockin_wait_counter u_wait_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_terminal),
        .hit      (cnt_hit)
    );

    // Next-state and next-output logic; every bus output is loaded one cycle ahead so it is registered.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        cmd_write_d   = cmd_write_q;
        chipselect_d  = chipselect_q;
        write_n_d     = write_n_q;
        read_n_d      = read_n_q;
        address_d     = address_q;
        writedata_d   = writedata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_clear     = 1'b0;
        cnt_enable    = 1'b0;
        cnt_terminal  = TO_TERM;
        go_resp       = 1'b0;
        bus_release   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_clear   = 1'b1;
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d  = 1'b0;
                    cmd_write_d  = cmd_write;
                    chipselect_d = 1'b1;
                    write_n_d    = ~cmd_write;
                    read_n_d     = cmd_write;
                    address_d    = cmd_addr;
                    writedata_d  = cmd_wdata;
                    state_d      = ST_BUS;
                end
            end
            ST_BUS: begin
                if (waitrequest) begin
                    cnt_enable = 1'b1;
                    if (cnt_hit) begin
                        go_resp       = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                    end
                end else if (cmd_write_q) begin
                    go_resp       = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                end else if (READ_LATENCY == 0) begin
                    go_resp       = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = readdata;
                end else begin
                    cnt_clear   = 1'b1;
                    bus_release = 1'b1;
                    state_d     = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                cnt_enable   = 1'b1;
                cnt_terminal = RL_TERM;
                if (cnt_hit) begin
                    go_resp       = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = readdata;
                end
            end
            ST_RESP: begin
                cnt_clear   = 1'b1;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_resp) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            bus_release = 1'b1;
        end

        if (bus_release) begin
            chipselect_d = 1'b0;
            write_n_d    = 1'b1;
            read_n_d     = 1'b1;
            address_d    = '0;
            writedata_d  = '0;
        end
    end

    // State and registered outputs; reset drops the bus immediately, even mid-transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            chipselect_q  <= 1'b0;
            write_n_q     <= 1'b1;
            read_n_q      <= 1'b1;
            address_q     <= '0;
            writedata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            cmd_write_q   <= cmd_write_d;
            chipselect_q  <= chipselect_d;
            write_n_q     <= write_n_d;
            read_n_q      <= read_n_d;
            address_q     <= address_d;
            writedata_q   <= writedata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign chipselect  = chipselect_q;
    assign write_n     = write_n_q;
    assign read_n      = read_n_q;
    assign address     = address_q;
    assign writedata   = writedata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
